// File: rtl/pattern_stream_gen.sv
// Test-pattern source producing the VSYNC/HSYNC dual-pixel stream of image_read.
// Gradient, checker, colour bars or solid fill; every output is registered.
module pattern_stream_gen #(
  parameter int unsigned WIDTH          = 768,
  parameter int unsigned HEIGHT         = 512,
  parameter int unsigned START_UP_DELAY = 100,
  parameter int unsigned HSYNC_DELAY    = 160,
  parameter int unsigned CHK_LOG2       = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [23:0] fill_rgb,
  output logic        VSYNC,
  output logic        HSYNC,
  output logic [7:0]  DATA_R0,
  output logic [7:0]  DATA_G0,
  output logic [7:0]  DATA_B0,
  output logic [7:0]  DATA_R1,
  output logic [7:0]  DATA_G1,
  output logic [7:0]  DATA_B1,
  output logic        ctrl_done
);

  localparam int unsigned Pairs  = WIDTH / 2;
  localparam int unsigned BarW   = WIDTH / 8;
  localparam int unsigned MaxDly = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
  localparam int unsigned DlyW   = $clog2(MaxDly + 1);
  localparam int unsigned ColW   = $clog2(Pairs);
  localparam int unsigned RowW   = $clog2(HEIGHT + 1);

  localparam logic [DlyW-1:0] VsyncLast = DlyW'(START_UP_DELAY - 1);
  localparam logic [DlyW-1:0] BlankLast = DlyW'(HSYNC_DELAY - 1);
  localparam logic [ColW-1:0] ColLast   = ColW'(Pairs - 1);
  localparam logic [RowW-1:0] RowLast   = RowW'(HEIGHT - 1);

  typedef enum logic [2:0] {StIdle, StVsync, StBlank, StData, StDone} state_e;

  state_e          state_q, state_d;
  logic [DlyW-1:0] dly_q, dly_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [1:0]      mode_q, mode_d;
  logic [23:0]     fill_q, fill_d;
  logic            vsync_q, vsync_d;
  logic            hsync_q, hsync_d;
  logic            done_q, done_d;
  logic [23:0]     pix0_q, pix0_d;
  logic [23:0]     pix1_q, pix1_d;

  // col is the full pixel column (pair index with the pixel-select bit appended).
  function automatic logic [23:0] pixel(input logic [1:0] m, input logic [23:0] fill,
                                        input logic [ColW:0] col, input logic [RowW-1:0] row);
    logic [7:0] c8, r8, on;
    logic [2:0] bar;
    c8  = 8'(col);
    r8  = 8'(row);
    on  = (col[CHK_LOG2] ^ row[CHK_LOG2]) ? 8'h00 : 8'hFF;
    bar = 3'(32'(col) / BarW);
    case (m)
      2'd0:    pixel = {c8, r8, 8'(c8 + r8)};
      2'd1:    pixel = {on, on, on};
      2'd2:    pixel = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
      default: pixel = fill;
    endcase
  endfunction

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      dly_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      mode_q  <= '0;
      fill_q  <= '0;
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      done_q  <= 1'b0;
      pix0_q  <= '0;
      pix1_q  <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      col_q   <= col_d;
      row_q   <= row_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      vsync_q <= vsync_d;
      hsync_q <= hsync_d;
      done_q  <= done_d;
      pix0_q  <= pix0_d;
      pix1_q  <= pix1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    col_d   = col_q;
    row_d   = row_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StVsync;
          dly_d   = '0;
          col_d   = '0;
          row_d   = '0;
          mode_d  = mode;
          fill_d  = fill_rgb;
        end
      end
      StVsync: begin
        if (dly_q == VsyncLast) begin
          state_d = StBlank;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + DlyW'(1);
        end
      end
      StBlank: begin
        if (dly_q == BlankLast) begin
          state_d = StData;
          col_d   = '0;
        end else begin
          dly_d = dly_q + DlyW'(1);
        end
      end
      StData: begin
        if (col_q == ColLast) begin
          dly_d = '0;
          if (row_q == RowLast) begin
            state_d = StDone;
          end else begin
            state_d = StBlank;
            row_d   = row_q + RowW'(1);
          end
        end else begin
          col_d = col_q + ColW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are derived from the next state so they line up with the state entered.
  always_comb begin
    vsync_d = (state_d == StVsync);
    hsync_d = (state_d == StData);
    done_d  = (state_d == StDone);
    pix0_d  = '0;
    pix1_d  = '0;
    if (hsync_d) begin
      pix0_d = pixel(mode_d, fill_d, {col_d, 1'b0}, row_d);
      pix1_d = pixel(mode_d, fill_d, {col_d, 1'b1}, row_d);
    end
  end

  assign VSYNC     = vsync_q;
  assign HSYNC     = hsync_q;
  assign ctrl_done = done_q;
  assign DATA_R0   = pix0_q[23:16];
  assign DATA_G0   = pix0_q[15:8];
  assign DATA_B0   = pix0_q[7:0];
  assign DATA_R1   = pix1_q[23:16];
  assign DATA_G1   = pix1_q[15:8];
  assign DATA_B1   = pix1_q[7:0];

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Bench for pattern_stream_gen: per-cycle compare against a frame-position model,
// plus directed literal checks of timing and pattern values.
module tb_pattern_stream_gen;

  localparam int W     = 16;
  localparam int H     = 4;
  localparam int SUD   = 3;
  localparam int HD    = 2;
  localparam int CHK   = 2;
  localparam int ROWC  = HD + W / 2;
  localparam int FRAME = SUD + H * ROWC;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        start;
  logic [1:0]  mode;
  logic [23:0] fill_rgb;
  logic        VSYNC, HSYNC, ctrl_done;
  logic [7:0]  DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
  logic [50:0] outs;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Model state: phase 0 idle, 1 in frame (t = cycles since accepted start), 2 done.
  int          m_phase = 0;
  int          m_t = 0;
  logic [1:0]  m_mode = '0;
  logic [23:0] m_fill = '0;
  logic        seen = 1'b0;

  pattern_stream_gen #(
    .WIDTH(W), .HEIGHT(H), .START_UP_DELAY(SUD), .HSYNC_DELAY(HD), .CHK_LOG2(CHK)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mode(mode), .fill_rgb(fill_rgb),
    .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .ctrl_done(ctrl_done)
  );

  always #5 HCLK = ~HCLK;

  assign outs = {VSYNC, HSYNC, ctrl_done, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1};

  task automatic check(input string name, input logic [50:0] act, input logic [50:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [23:0] exp_pix(input logic [1:0] m, input logic [23:0] fill,
                                          input int col, input int row);
    int s, b;
    logic [31:0] sv, cv, rv;
    cv = col;
    rv = row;
    s  = col + row;
    sv = s;
    b  = col / (W / 8);
    case (m)
      2'd0: return {cv[7:0], rv[7:0], sv[7:0]};
      2'd1: return ((((col >> CHK) ^ (row >> CHK)) & 1) == 0) ? 24'hFFFFFF : 24'h000000;
      2'd2: return {((b & 4) != 0) ? 8'hFF : 8'h00, ((b & 2) != 0) ? 8'hFF : 8'h00,
                    ((b & 1) != 0) ? 8'hFF : 8'h00};
      default: return fill;
    endcase
  endfunction

  function automatic logic [50:0] expect_outs(input int ph, input int t, input logic [1:0] m,
                                              input logic [23:0] fill);
    logic vs, hs, dn;
    logic [23:0] p0, p1;
    int u, row, w, cp;
    vs = 0; hs = 0; dn = (ph == 2); p0 = '0; p1 = '0;
    if (ph == 1) begin
      if (t < SUD) vs = 1;
      else begin
        u   = t - SUD;
        row = u / ROWC;
        w   = u % ROWC;
        if (w >= HD) begin
          hs = 1;
          cp = w - HD;
          p0 = exp_pix(m, fill, 2 * cp, row);
          p1 = exp_pix(m, fill, 2 * cp + 1, row);
        end
      end
    end
    return {vs, hs, dn, p0, p1};
  endfunction

  always @(posedge HCLK) begin
    seen <= 1'b1;
    if (!HRESETn) begin
      m_phase <= 0;
      m_t     <= 0;
    end else if (m_phase != 1 && start) begin
      m_phase <= 1;
      m_t     <= 0;
      m_mode  <= mode;
      m_fill  <= fill_rgb;
    end else if (m_phase == 1) begin
      if (m_t == FRAME - 1) m_phase <= 2;
      else m_t <= m_t + 1;
    end
  end

  always @(negedge HCLK) begin
    if (seen) check("cycle", outs, expect_outs(m_phase, m_t, m_mode, m_fill));
  end

  task automatic adv(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [23:0] f);
    start    = 1'b1;
    mode     = m;
    fill_rgb = f;
    adv(1);
    start = 1'b0;
  endtask

  task automatic run_to_done(input int t0, input string name);
    int n;
    n = t0;
    while (!ctrl_done && n < 200) begin
      adv(1);
      n++;
    end
    check(name, 51'(n), 51'(FRAME));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b0; start = 1'b1; mode = 2'd0; fill_rgb = 24'h0;
    adv(4);
    check("reset_outputs", outs, '0);
    HRESETn = 1'b1; start = 1'b0;
    adv(5);
    check("idle_no_start", outs, '0);

    // Frame A: gradient and timing
    pulse_start(2'd0, 24'h0);
    check("vsync_t0", 51'(VSYNC), 51'(1));
    adv(2);
    check("vsync_t2", 51'(VSYNC), 51'(1));
    adv(1);
    check("blank_t3", 51'({VSYNC, HSYNC}), 51'(0));
    adv(2);
    check("hsync_t5", 51'(HSYNC), 51'(1));
    adv(23);
    check("grad_pix0", 51'({DATA_R0, DATA_G0, DATA_B0}), 51'(24'h060208));
    check("grad_pix1", 51'({DATA_R1, DATA_G1, DATA_B1}), 51'(24'h070209));
    run_to_done(28, "frame_len_grad");
    adv(5);
    check("done_held", 51'(ctrl_done), 51'(1));

    // Frame B: checker, started from DONE
    pulse_start(2'd1, 24'h0);
    check("restart_from_done", 51'({VSYNC, ctrl_done}), 51'(2'b10));
    adv(5);
    check("chk_pair0", 51'({DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1}),
          51'(48'hFFFFFF_FFFFFF));
    adv(1);
    check("chk_pair1", 51'({DATA_R0, DATA_B1}), 51'(16'hFFFF));
    adv(1);
    check("chk_pair2", 51'({DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1}), 51'(0));
    adv(1);
    check("chk_pair3", 51'({DATA_R0, DATA_B1}), 51'(0));
    run_to_done(8, "frame_len_chk");

    // Frame C: bars
    pulse_start(2'd2, 24'h0);
    adv(10);
    check("bars_pair5", 51'({DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1}),
          51'(48'hFF00FF_FF00FF));
    run_to_done(10, "frame_len_bars");

    // Frame D: solid fill, inputs changed and start pulsed mid-frame
    pulse_start(2'd3, 24'h123456);
    adv(18);
    fill_rgb = 24'hABCDEF; mode = 2'd0; start = 1'b1;
    adv(1);
    start = 1'b0;
    adv(11);
    check("solid_pix", 51'({DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1}),
          51'(48'h123456_123456));
    run_to_done(30, "frame_len_no_restart");

    // Frame E: reset during row 1 DATA, then a full frame
    pulse_start(2'd0, 24'h0);
    adv(16);
    check("row1_data", 51'(HSYNC), 51'(1));
    HRESETn = 1'b0;
    adv(1);
    check("midframe_reset", outs, '0);
    HRESETn = 1'b1;
    adv(2);
    check("idle_after_reset", outs, '0);
    pulse_start(2'd0, 24'h0);
    run_to_done(0, "frame_len_after_reset");
    adv(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
